// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin share of NUM_PORTS writeback ports among NUM_REQ result sources.
// Optional WB_ARB_AGE_EN: per-requester wait counters promote starved requesters first.
`ifndef NUM_PR
`define NUM_PR 64
`endif
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module wb_port_arbiter #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = 4,
  parameter int PR_W      = $clog2(`NUM_PR),
  parameter int AL_W      = $clog2(`AL_SIZE),
  parameter int MAX_WAIT  = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ext_stall,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_uses_rd,
  input  logic [NUM_REQ*PR_W-1:0]        req_rd,
  input  logic [NUM_REQ*32-1:0]          req_data,
  input  logic [NUM_REQ*AL_W-1:0]        req_al_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]           wb_valid,
  output logic [NUM_PORTS-1:0]           wb_uses_rd,
  output logic [NUM_PORTS*PR_W-1:0]      wb_rd,
  output logic [NUM_PORTS*32-1:0]        wb_data,
  output logic [NUM_PORTS*AL_W-1:0]      wb_al_addr,
  output logic [$clog2(NUM_PORTS+1)-1:0] grant_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(NUM_PORTS+1);

  logic [IW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_PORTS-1:0] port_vld;
  logic [IW-1:0]        port_src [NUM_PORTS];
  logic [CW-1:0]        n_gnt;
  logic                 rr_any;
  logic [IW-1:0]        rr_last;

`ifdef WB_ARB_AGE_EN
  logic [2:0] wait_q [NUM_REQ];
`endif

  // pick up to NUM_PORTS requesters, packing them onto ports from 0 upward
  always_comb begin
    logic [IW:0] idx;
    idx = '0;
    gnt = '0;
    port_vld = '0;
    n_gnt = '0;
    rr_any = 1'b0;
    rr_last = rr_ptr;
    for (int p = 0; p < NUM_PORTS; p++) port_src[p] = '0;
    if (!ext_stall) begin
`ifdef WB_ARB_AGE_EN
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && wait_q[i] == 3'(MAX_WAIT) &&
            n_gnt < CW'(NUM_PORTS)) begin
          gnt[i] = 1'b1;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (n_gnt == CW'(p)) begin
              port_vld[p] = 1'b1;
              port_src[p] = IW'(i);
            end
          end
          n_gnt = n_gnt + 1'b1;
        end
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, rr_ptr} + (IW+1)'(k);
        if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
        if (req_valid[idx[IW-1:0]] && !gnt[idx[IW-1:0]] &&
            n_gnt < CW'(NUM_PORTS)) begin
          gnt[idx[IW-1:0]] = 1'b1;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (n_gnt == CW'(p)) begin
              port_vld[p] = 1'b1;
              port_src[p] = idx[IW-1:0];
            end
          end
          n_gnt = n_gnt + 1'b1;
          rr_any = 1'b1;
          rr_last = idx[IW-1:0];
        end
      end
    end
  end

  assign req_ready = gnt & {NUM_REQ{reset}};

  // register granted results onto the writeback bus and advance the pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid   <= '0;
      wb_uses_rd <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_al_addr <= '0;
      grant_cnt  <= '0;
      rr_ptr     <= '0;
    end else begin
      grant_cnt <= n_gnt;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wb_valid[p]   <= port_vld[p];
        wb_uses_rd[p] <= req_uses_rd[port_src[p]];
        wb_rd[p*PR_W +: PR_W] <= req_rd[port_src[p]*PR_W +: PR_W];
        wb_data[p*32 +: 32]   <= req_data[port_src[p]*32 +: 32];
        wb_al_addr[p*AL_W +: AL_W] <= req_al_addr[port_src[p]*AL_W +: AL_W];
      end
      if (rr_any) begin
        rr_ptr <= (rr_last == IW'(NUM_REQ-1)) ? '0 : rr_last + 1'b1;
      end
    end
  end

`ifdef WB_ARB_AGE_EN
  // count cycles a valid requester is passed over, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else if (!ext_stall) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || gnt[i]) wait_q[i] <= '0;
        else if (wait_q[i] != 3'(MAX_WAIT)) wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random checks of wb_port_arbiter
// against a queue-based scan model of the grant rules.
module tb_wb_port_arbiter;
  localparam int N = 6, P = 4, PR_W = 6, AL_W = 5, CW = 3;

  logic clk = 1'b0;
  logic reset, ext_stall;
  logic [N-1:0]      req_valid, req_uses_rd, req_ready;
  logic [N*PR_W-1:0] req_rd;
  logic [N*32-1:0]   req_data;
  logic [N*AL_W-1:0] req_al_addr;
  logic [P-1:0]      wb_valid, wb_uses_rd;
  logic [P*PR_W-1:0] wb_rd;
  logic [P*32-1:0]   wb_data;
  logic [P*AL_W-1:0] wb_al_addr;
  logic [CW-1:0]     grant_cnt;

  wb_port_arbiter #(.NUM_REQ(N), .NUM_PORTS(P), .PR_W(PR_W), .AL_W(AL_W)) dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .req_valid(req_valid), .req_uses_rd(req_uses_rd), .req_rd(req_rd),
    .req_data(req_data), .req_al_addr(req_al_addr), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_uses_rd(wb_uses_rd), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_al_addr(wb_al_addr), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int m_rr, rr_hit, exp_n;
  int m_wait [N];
  int starve [N];
  logic [N-1:0] exp_gnt, seen_rdy;
  logic [P-1:0] e_vld, e_urd;
  logic [PR_W-1:0] e_rd [P];
  logic [31:0]     e_dat [P];
  logic [AL_W-1:0] e_al [P];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, logic v, logic u, int rd, logic [31:0] d, int al);
    req_valid[i] = v;
    req_uses_rd[i] = u;
    req_rd[i*PR_W +: PR_W] = PR_W'(rd);
    req_data[i*32 +: 32] = d;
    req_al_addr[i*AL_W +: AL_W] = AL_W'(al);
  endtask

  task automatic rand_req(int i, logic v);
    set_req(i, v, 1'($urandom), int'($urandom_range(0, 63)), $urandom,
            int'($urandom_range(0, 31)));
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < N; i++) begin
      m_wait[i] = 0;
      starve[i] = 0;
    end
  endtask

  // grants: aged requesters first (if enabled), then circular scan from m_rr
  task automatic model_grants();
    int q[$];
    exp_gnt = '0;
    rr_hit = -1;
    if (!ext_stall) begin
`ifdef WB_ARB_AGE_EN
      for (int i = 0; i < N; i++)
        if (req_valid[i] && m_wait[i] == 7 && q.size() < P) begin
          q.push_back(i);
          exp_gnt[i] = 1'b1;
        end
`endif
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (req_valid[idx] && !exp_gnt[idx] && q.size() < P) begin
          q.push_back(idx);
          exp_gnt[idx] = 1'b1;
          rr_hit = idx;
        end
      end
    end
    exp_n = q.size();
    e_vld = '0;
    e_urd = '0;
    for (int p = 0; p < P; p++) begin
      e_rd[p] = '0;
      e_dat[p] = '0;
      e_al[p] = '0;
      if (p < exp_n) begin
        e_vld[p] = 1'b1;
        e_urd[p] = req_uses_rd[q[p]];
        e_rd[p] = req_rd[q[p]*PR_W +: PR_W];
        e_dat[p] = req_data[q[p]*32 +: 32];
        e_al[p] = req_al_addr[q[p]*AL_W +: AL_W];
      end
    end
  endtask

  task automatic cycle();
    model_grants();
    #1;
    seen_rdy = req_ready;
    chk("req_ready", req_ready, exp_gnt);
    @(posedge clk);
    #1;
    chk("wb_valid", wb_valid, e_vld);
    chk("grant_cnt", grant_cnt, exp_n);
    for (int p = 0; p < P; p++)
      if (e_vld[p]) begin
        chk("wb_uses_rd", wb_uses_rd[p], e_urd[p]);
        chk("wb_rd", wb_rd[p*PR_W +: PR_W], e_rd[p]);
        chk("wb_data", wb_data[p*32 +: 32], e_dat[p]);
        chk("wb_al_addr", wb_al_addr[p*AL_W +: AL_W], e_al[p]);
      end
    if (!ext_stall) begin
      if (rr_hit >= 0) m_rr = (rr_hit + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !exp_gnt[i]) begin
          starve[i]++;
          m_wait[i] = (m_wait[i] < 7) ? m_wait[i] + 1 : 7;
          chk("starve_bound", starve[i] <= 1, 1);
        end else begin
          starve[i] = 0;
          m_wait[i] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    ext_stall = 1'b0;
    for (int i = 0; i < N; i++) rand_req(i, 1'b1);
    model_reset();
    #12;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant_cnt", grant_cnt, 0);
    @(negedge clk);
    reset = 1'b1;

    cycle();
    chk("dir_first", seen_rdy, 6'b001111);
    chk("dir_first_wb", wb_valid, 4'b1111);
    for (int i = 0; i < N; i++) if (seen_rdy[i]) rand_req(i, 1'b1);
    cycle();
    chk("dir_wrap", seen_rdy, 6'b110011);
    for (int i = 0; i < N; i++) if (seen_rdy[i]) rand_req(i, 1'b1);
    cycle();
    chk("dir_next", seen_rdy, 6'b111100);

    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0, 32'h0, 0);
    set_req(5, 1'b1, 1'b1, 9, 32'hDEADBEEF, 3);
    cycle();
    chk("sparse_wb", wb_valid, 4'b0001);
    chk("sparse_rd", wb_rd[PR_W-1:0], 9);
    chk("sparse_data", wb_data[31:0], 32'hDEADBEEF);

    for (int i = 0; i < N; i++) rand_req(i, 1'b1);
    ext_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("stall_ready", seen_rdy, 0);
      chk("stall_wb", wb_valid, 0);
    end
    ext_stall = 1'b0;
    cycle();
    chk("stall_release", seen_rdy, 6'b001111);

    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0, 32'h0, 0);
    set_req(2, 1'b1, 1'b0, 17, 32'h1234_5678, 5);
    cycle();
    chk("nouse_wb", wb_valid, 4'b0001);
    chk("nouse_urd", wb_uses_rd[0], 1'b0);
    chk("nouse_al", wb_al_addr[AL_W-1:0], 5);
    set_req(2, 1'b0, 1'b0, 0, 32'h0, 0);

    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (seen_rdy[i]) rand_req(i, 1'($urandom_range(0, 3) != 0));
        else if (!req_valid[i]) rand_req(i, 1'($urandom));
      end
      ext_stall = ($urandom_range(0, 7) == 0);
      if (c == 150) begin
        ext_stall = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_wb", wb_valid, 0);
        chk("mid_rst_cnt", grant_cnt, 0);
        chk("mid_rst_ready", req_ready, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        seen_rdy = '0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's four writeback ports among NUM_REQ execution-unit result sources: 2 ALU, 2 memory, multiply, divide.
- Each cycle, grants up to NUM_PORTS valid requesters in round-robin order.
- Registers the granted results onto the writeback bus that feeds the register file and the active-list completion logic.
- Ungranted requesters hold their result until granted. Backpressure uses a valid/ready handshake.

Parameters:
- NUM_REQ, 6, number of result requesters.
- NUM_PORTS, 4, number of register-file writeback ports; must be less than or equal to NUM_REQ.
- PR_W, $clog2(`NUM_PR), physical register address width.
- AL_W, $clog2(`AL_SIZE), active-list address width.
- MAX_WAIT, 7, starvation threshold in cycles; used only with the optional feature.

Ports:
- clk  in  1  single core clock.
- reset  in  1  asynchronous, active-low reset (clears state while 0).
- ext_stall  in  1  pipeline stall; no grants are issued while high.
- req_valid  in  NUM_REQ  requester i has a result.
- req_uses_rd  in  NUM_REQ  result writes a destination register.
- req_rd  in  NUM_REQ*PR_W  destination physical register; slice i belongs to requester i.
- req_data  in  NUM_REQ*32  result data.
- req_al_addr  in  NUM_REQ*AL_W  active-list entry to mark complete.
- req_ready  out  NUM_REQ  requester i granted this cycle; it drops or replaces its result at the clock edge.
- wb_valid  out  NUM_PORTS  writeback port p carries a result.
- wb_uses_rd  out  NUM_PORTS  port p writes the register file.
- wb_rd  out  NUM_PORTS*PR_W  destination register per port.
- wb_data  out  NUM_PORTS*32  data per port.
- wb_al_addr  out  NUM_PORTS*AL_W  active-list address per port.
- grant_cnt  out  $clog2(NUM_PORTS+1)  number of grants issued in the previous cycle, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - wb_valid=0, wb_uses_rd=0, wb_rd=0, wb_data=0, wb_al_addr=0.
  - grant_cnt=0, rr_ptr=0, all wait counters=0.
  - req_ready is combinational and is 0 while reset is asserted.
- Grant logic (combinational):
  - Scan requesters circularly from rr_ptr: rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first NUM_PORTS requesters found with req_valid=1 are granted.
  - The k-th granted requester in scan order is assigned port k; ports are packed from port 0 with no gaps.
  - req_ready[i]=1 iff requester i is granted and ext_stall=0.
  - req_ready depends combinationally on req_valid. Requesters must not make valid depend on ready.
- Output register:
  - At each posedge, port k takes the k-th granted requester's uses_rd, rd, data and al_addr, and wb_valid[k]=1.
  - Ports with no grant get wb_valid=0; their other fields are don't-care.
  - Latency is exactly one cycle from handshake (valid and ready) to the wb_* outputs.
- Pointer update: if at least one grant is issued, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. Otherwise rr_ptr holds.
- ext_stall=1:
  - No grants are issued; all req_ready=0.
  - Next cycle wb_valid=0 on all ports and grant_cnt=0.
  - rr_ptr and wait counters hold.
  - No duplicate writes occur after the stall is released.
- Boundary cases:
  - 0 valid: all wb_valid=0 next cycle.
  - Exactly NUM_PORTS valid: all are granted.
  - More than NUM_PORTS valid: the surplus wait, and are guaranteed to be granted within ceil(NUM_REQ/NUM_PORTS) cycles of continuous non-stall operation.
  - Wrap-around: when rr_ptr=NUM_REQ-1 the scan continues at index 0.
- Non-interference:
  - Two grants that target the same rd in one cycle are both forwarded, in port order.
  - The register file resolves same-rd ordering; the arbiter does not compare rd values.
  - wb_uses_rd=0 entries still occupy a port, because active-list completion requires it.
- Reset asserted mid-operation: in-flight wb_valid clears immediately (asynchronous). Requesters must re-present their results after reset.

Optional Feature:
- Macro: WB_ARB_AGE_EN.
- Defined:
  - Each requester has a 3-bit wait counter.
  - The counter increments while req_valid=1, the requester is not granted, and ext_stall=0. It saturates at MAX_WAIT and clears on grant or when req_valid=0.
  - Requesters whose counter equals MAX_WAIT are granted first, in ascending index order, before the round-robin scan fills the remaining ports.
  - rr_ptr updates only from round-robin grants.
- Undefined: no wait counters; pure round-robin as described above.

Test Plan:
- Reset: hold reset=0, then release; drive req_valid=6'b111111 -> during reset wb_valid=0 and req_ready=0. First cycle after release: requesters 0-3 granted, wb_valid=4'b1111 next cycle, rr_ptr=4, grant_cnt=4.
- Round-robin wrap: all 6 valid continuously with rr_ptr=4 -> grants 4,5,0,1 on ports 0-3; next cycle grants 2,3,4,5.
- Sparse request: only req_valid[5], rd=9, data=32'hDEADBEEF -> next cycle wb_valid=4'b0001, wb_rd[0]=9, wb_data[0]=32'hDEADBEEF, rr_ptr=0.
- Stall: all 6 valid and ext_stall=1 for 3 cycles -> req_ready=0, wb_valid=0, grant_cnt=0 throughout. On release, grants resume from the unchanged rr_ptr.
- uses_rd=0: requester 2 valid with uses_rd=0 and al_addr=5 -> port 0 has wb_valid=1, wb_uses_rd=0, wb_al_addr=5.
- WB_ARB_AGE_EN: requesters 0-4 held valid and a forced wait counter for requester 4 at 7 -> requester 4 granted on port 0 that cycle, counter cleared.
